// File: rtl/cpc_kbd_pkg.sv
// Shared constants and types for the CPC keyboard matrix block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpc_kbd_pkg;

    localparam int KBD_ROWS    = 10;
    localparam int JOY0_ROW    = 9;
    localparam int JOY1_ROW    = 6;
    localparam int PS2_EXT_BIT = 8;
    localparam int PS2_TGL_BIT = 10;

    // Matrix position produced by the keymap ROM; hit=0 means "not a CPC key".
    typedef struct packed {
        logic       hit;
        logic [3:0] row;
        logic [2:0] bit_;
    } kpos_t;

    function automatic kpos_t key_at(input logic [3:0] row, input logic [2:0] bit_);
        kpos_t p;
        p.hit  = 1'b1;
        p.row  = row;
        p.bit_ = bit_;
        return p;
    endfunction

endpackage

// File: rtl/cpc_key_matrix_keymap.sv
// PS/2 set-2 scan code (with E0 flag in bit 8) to CPC matrix row/bit ROM.
// Latency: purely combinational.
// Backpressure: none; output follows the code input.
module cpc_keymap
    import cpc_kbd_pkg::*;
(
    input  logic [8:0] code,
    output kpos_t      pos
);

    // Case ROM; keypad digits alias onto the CPC F0..F9 keypad keys.
    always_comb begin
        pos = '0;
        case (code)
            // row 0: cursor up/right/down, F9 F6 F3, small Enter, keypad dot
            9'h175: pos = key_at(4'd0, 3'd0);
            9'h174: pos = key_at(4'd0, 3'd1);
            9'h172: pos = key_at(4'd0, 3'd2);
            9'h001: pos = key_at(4'd0, 3'd3);
            9'h07D: pos = key_at(4'd0, 3'd3);
            9'h00B: pos = key_at(4'd0, 3'd4);
            9'h074: pos = key_at(4'd0, 3'd4);
            9'h004: pos = key_at(4'd0, 3'd5);
            9'h07A: pos = key_at(4'd0, 3'd5);
            9'h15A: pos = key_at(4'd0, 3'd6);
            9'h071: pos = key_at(4'd0, 3'd7);
            // row 1: cursor left, Copy, F7 F8 F5 F1 F2 F0
            9'h16B: pos = key_at(4'd1, 3'd0);
            9'h17A: pos = key_at(4'd1, 3'd1);
            9'h083: pos = key_at(4'd1, 3'd2);
            9'h06C: pos = key_at(4'd1, 3'd2);
            9'h00A: pos = key_at(4'd1, 3'd3);
            9'h075: pos = key_at(4'd1, 3'd3);
            9'h003: pos = key_at(4'd1, 3'd4);
            9'h073: pos = key_at(4'd1, 3'd4);
            9'h005: pos = key_at(4'd1, 3'd5);
            9'h069: pos = key_at(4'd1, 3'd5);
            9'h006: pos = key_at(4'd1, 3'd6);
            9'h072: pos = key_at(4'd1, 3'd6);
            9'h009: pos = key_at(4'd1, 3'd7);
            9'h070: pos = key_at(4'd1, 3'd7);
            // row 2: Clr [ Return ] F4 Shift \ Control
            9'h171: pos = key_at(4'd2, 3'd0);
            9'h054: pos = key_at(4'd2, 3'd1);
            9'h05A: pos = key_at(4'd2, 3'd2);
            9'h05B: pos = key_at(4'd2, 3'd3);
            9'h00C: pos = key_at(4'd2, 3'd4);
            9'h06B: pos = key_at(4'd2, 3'd4);
            9'h012: pos = key_at(4'd2, 3'd5);
            9'h059: pos = key_at(4'd2, 3'd5);
            9'h05D: pos = key_at(4'd2, 3'd6);
            9'h014: pos = key_at(4'd2, 3'd7);
            9'h114: pos = key_at(4'd2, 3'd7);
            // row 3: ^ - @ P ; : / .
            9'h055: pos = key_at(4'd3, 3'd0);
            9'h04E: pos = key_at(4'd3, 3'd1);
            9'h00E: pos = key_at(4'd3, 3'd2);
            9'h04D: pos = key_at(4'd3, 3'd3);
            9'h04C: pos = key_at(4'd3, 3'd4);
            9'h052: pos = key_at(4'd3, 3'd5);
            9'h04A: pos = key_at(4'd3, 3'd6);
            9'h049: pos = key_at(4'd3, 3'd7);
            // row 4: 0 9 O I L K M ,
            9'h045: pos = key_at(4'd4, 3'd0);
            9'h046: pos = key_at(4'd4, 3'd1);
            9'h044: pos = key_at(4'd4, 3'd2);
            9'h043: pos = key_at(4'd4, 3'd3);
            9'h04B: pos = key_at(4'd4, 3'd4);
            9'h042: pos = key_at(4'd4, 3'd5);
            9'h03A: pos = key_at(4'd4, 3'd6);
            9'h041: pos = key_at(4'd4, 3'd7);
            // row 5: 8 7 U Y H J N Space
            9'h03E: pos = key_at(4'd5, 3'd0);
            9'h03D: pos = key_at(4'd5, 3'd1);
            9'h03C: pos = key_at(4'd5, 3'd2);
            9'h035: pos = key_at(4'd5, 3'd3);
            9'h033: pos = key_at(4'd5, 3'd4);
            9'h03B: pos = key_at(4'd5, 3'd5);
            9'h031: pos = key_at(4'd5, 3'd6);
            9'h029: pos = key_at(4'd5, 3'd7);
            // row 6: 6 5 R T G F B V
            9'h036: pos = key_at(4'd6, 3'd0);
            9'h02E: pos = key_at(4'd6, 3'd1);
            9'h02D: pos = key_at(4'd6, 3'd2);
            9'h02C: pos = key_at(4'd6, 3'd3);
            9'h034: pos = key_at(4'd6, 3'd4);
            9'h02B: pos = key_at(4'd6, 3'd5);
            9'h032: pos = key_at(4'd6, 3'd6);
            9'h02A: pos = key_at(4'd6, 3'd7);
            // row 7: 4 3 E W S D C X
            9'h025: pos = key_at(4'd7, 3'd0);
            9'h026: pos = key_at(4'd7, 3'd1);
            9'h024: pos = key_at(4'd7, 3'd2);
            9'h01D: pos = key_at(4'd7, 3'd3);
            9'h01B: pos = key_at(4'd7, 3'd4);
            9'h023: pos = key_at(4'd7, 3'd5);
            9'h021: pos = key_at(4'd7, 3'd6);
            9'h022: pos = key_at(4'd7, 3'd7);
            // row 8: 1 2 Esc Q Tab A CapsLock Z
            9'h016: pos = key_at(4'd8, 3'd0);
            9'h01E: pos = key_at(4'd8, 3'd1);
            9'h076: pos = key_at(4'd8, 3'd2);
            9'h015: pos = key_at(4'd8, 3'd3);
            9'h00D: pos = key_at(4'd8, 3'd4);
            9'h01C: pos = key_at(4'd8, 3'd5);
            9'h058: pos = key_at(4'd8, 3'd6);
            9'h01A: pos = key_at(4'd8, 3'd7);
            // row 9: Del (bits 5..0 belong to joystick 0)
            9'h066: pos = key_at(4'd9, 3'd7);
            default: pos = '0;
        endcase
    end

endmodule

// File: rtl/cpc_key_matrix.sv
// PS/2 events + joysticks -> CPC key matrix with tap stretching, read by row select.
// Latency: col_n/any_key registered, 1 cycle after row_sel or matrix change.
// Backpressure: none; every ps2 toggle is consumed in the cycle it appears.
module cpc_key_matrix
    import cpc_kbd_pkg::*;
#(
    parameter int ROWS   = KBD_ROWS,
    parameter bit JOY_EN = 1'b1
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [10:0] ps2_key,
    input  logic [5:0]  joy0,
    input  logic [5:0]  joy1,
    input  logic [3:0]  row_sel,
    input  logic        row_rd,
    input  logic        key_clear,
    output logic [7:0]  col_n,
    output logic        any_key
);

    localparam logic [4:0] ROWS_W = 5'(ROWS);

    logic       tgl_q;
    logic [7:0] key_q  [ROWS];
    logic [7:0] seen_q [ROWS];
    logic [7:0] pend_q [ROWS];
    logic [7:0] key_n  [ROWS];
    logic [7:0] seen_n [ROWS];
    logic [7:0] pend_n [ROWS];

    kpos_t      pos;
    logic       evt;
    logic       sel_ok;
    logic       pos_ok;
    logic [7:0] jmask;
    logic [7:0] col_d;
    logic       any_d;

    cpc_keymap u_keymap (
        .code ({ps2_key[PS2_EXT_BIT], ps2_key[7:0]}),
        .pos  (pos)
    );

    assign evt    = ps2_key[PS2_TGL_BIT] != tgl_q;
    assign sel_ok = {1'b0, row_sel} < ROWS_W;
    assign pos_ok = pos.hit && ({1'b0, pos.row} < ROWS_W);

    // Next-state matrix: row read first, then the ps2 event, clear overrides both.
    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            key_n[r]  = key_q[r];
            seen_n[r] = seen_q[r];
            pend_n[r] = pend_q[r];
        end
        if (row_rd && sel_ok) begin
            seen_n[row_sel] = seen_q[row_sel] | key_q[row_sel];
            key_n[row_sel]  = key_q[row_sel] & ~pend_q[row_sel];
            pend_n[row_sel] = '0;
        end
        if (evt && pos_ok) begin
            if (ps2_key[9]) begin
                key_n[pos.row][pos.bit_]  = 1'b1;
                seen_n[pos.row][pos.bit_] = 1'b0;
                pend_n[pos.row][pos.bit_] = 1'b0;
            end else if (key_n[pos.row][pos.bit_]) begin
                // An unscanned tap is held until its row has been read once.
                if (seen_n[pos.row][pos.bit_]) begin
                    key_n[pos.row][pos.bit_] = 1'b0;
                end else begin
                    pend_n[pos.row][pos.bit_] = 1'b1;
                end
            end
        end
        if (key_clear) begin
            for (int r = 0; r < ROWS; r++) begin
                key_n[r]  = '0;
                seen_n[r] = '0;
                pend_n[r] = '0;
            end
        end
    end

    // Joystick overlay for the selected row.
    always_comb begin
        jmask = '0;
        if (JOY_EN) begin
            if (row_sel == 4'(JOY0_ROW)) begin
                jmask = {2'b00, joy0};
            end else if (row_sel == 4'(JOY1_ROW)) begin
                jmask = {2'b00, joy1};
            end
        end
    end

    // Column mux and any-key reduction feeding the output registers.
    always_comb begin
        col_d = 8'hFF;
        if (sel_ok) begin
            col_d = ~(key_q[row_sel] | jmask);
        end
        any_d = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            any_d = any_d | (|key_q[r]);
        end
    end

    // State and output registers; tracker loads the live toggle so reset replays nothing.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            tgl_q <= ps2_key[PS2_TGL_BIT];
            for (int r = 0; r < ROWS; r++) begin
                key_q[r]  <= '0;
                seen_q[r] <= '0;
                pend_q[r] <= '0;
            end
            col_n   <= 8'hFF;
            any_key <= 1'b0;
        end else begin
            tgl_q <= ps2_key[PS2_TGL_BIT];
            for (int r = 0; r < ROWS; r++) begin
                key_q[r]  <= key_n[r];
                seen_q[r] <= seen_n[r];
                pend_q[r] <= pend_n[r];
            end
            col_n   <= col_d;
            any_key <= any_d;
        end
    end

endmodule
